// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory port and mem_responder.
interface mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  err;

  modport master (output req, we, addr, wdata, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word RAM responder: one request at a time, one-cycle ready pulse.
// Optional MEM_RESP_ALIGN_CHECK_EN: misaligned addresses respond with err=1.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
  localparam int unsigned CNT_W  = 4;
`ifdef MEM_RESP_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif
  localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  CNT_INIT  = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  take_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic                  sel_bad_c;
  logic                  lat_bad_c;
  logic                  resp_next_c;

  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    return (a[ADDR_WIDTH-1:2] >= DEPTH_LIM) || (ALIGN_CHECK && (a[1:0] != 2'b00));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  // Next-state logic; the response address is the live bus when taken this cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          take_c = 1'b1;
          if (LATENCY <= 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sel_addr_c  = take_c ? bus.addr : addr_q;
    sel_bad_c   = addr_bad(sel_addr_c);
    lat_bad_c   = addr_bad(addr_q);
    resp_next_c = (state_d == RESP);
  end

  // State, request latch and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take_c) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      bus.ready <= resp_next_c;
      bus.err   <= resp_next_c && sel_bad_c;
      bus.rdata <= (resp_next_c && !sel_bad_c) ? mem[word_idx(sel_addr_c)] : '0;
    end
  end

  // RAM write commits at the edge closing the RESP cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == RESP) && we_q && !lat_bad_c) begin
      mem[word_idx(addr_q)] <= wdata_q;
    end
  end

endmodule
